exposure_seq: RTL
=================

EXPOSURE_SEQ -- requirements
Module: exposure_seq

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Init, input, 1 bit: exposure start request, sampled on rising Clk.
REQ-004 SHALL have port EX_time, input, 5 bits: exposure length in Clk cycles, unsigned; driven by the exposure-time control register.
REQ-005 SHALL have port Erase, output, 1 bit: pixel erase, active-high.
REQ-006 SHALL have port Expose, output, 1 bit: pixel integrate enable, active-high.
REQ-007 SHALL have port NRE_1, output, 1 bit: row-1 read enable, active-low.
REQ-008 SHALL have port NRE_2, output, 1 bit: row-2 read enable, active-low.
REQ-009 SHALL have port ADC, output, 1 bit: ADC convert strobe, active-high.
REQ-010 SHALL have port Busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have port Done, output, 1 bit: one-cycle pulse at the end of readout.

Function
REQ-012 SHALL implement FSM states IDLE, EXPOSE, READOUT; all outputs registered (no combinational path from inputs to outputs).
REQ-013 SHALL, in IDLE, drive Erase=1, Expose=0, NRE_1=1, NRE_2=1, ADC=0, Busy=0.
REQ-014 SHALL, when Init=1 at rising edge k in IDLE, enter EXPOSE at edge k and latch EX_time into a 5-bit exposure counter.
REQ-015 SHALL clamp the latched value: values below 2 become 2, values above 30 become 30.
REQ-016 SHALL hold Expose=1, Erase=0 for exactly N cycles (N = clamped value), i.e. from edge k to edge k+N.
REQ-017 SHALL ignore changes on EX_time after the latch; a new value takes effect only on the next Init.
REQ-018 SHALL enter READOUT at edge k+N and run a fixed 8-cycle sequence, indexed by phase p = 0..7: p0 NRE_1=0; p1 NRE_1=0, ADC=1; p2 NRE_1=1; p3 idle; p4 NRE_2=0; p5 NRE_2=0, ADC=1; p6 NRE_2=1; p7 idle.
REQ-019 SHALL never assert NRE_1 and NRE_2 low in the same cycle, and SHALL assert ADC only while exactly one NRE is low.
REQ-020 SHALL return to IDLE at edge k+N+8, with Done=1 for that single cycle.
REQ-021 SHALL ignore Init while Busy=1; no queuing.
REQ-022 SHALL treat Init held continuously high as a fresh request in each IDLE cycle; back-to-back runs start on the cycle after Done.
REQ-023 SHALL keep the exposure counter and the readout phase counter from wrapping; both saturate at their terminal count.

Reset
REQ-024 SHALL, on Reset=1 in any state, immediately force state IDLE, zero both counters, and drive outputs Erase=1, Expose=0, NRE_1=1, NRE_2=1, ADC=0, Busy=0, Done=0.
REQ-025 SHALL abort exposure or readout in progress on mid-operation Reset, with no Done pulse; Init is ignored while Reset=1.
REQ-026 SHALL accept Init on the first rising Clk edge after Reset deasserts.

Structure
REQ-027 SHALL place the state enumeration and the constants EXP_MIN=2, EXP_MAX=30, READOUT_LEN=8 in a shared package, exposure_pkg.
REQ-028 SHALL implement the exposure counter as a single sub-module, exposure_counter: 5-bit clamped load with down-count and terminal-count flag.

Verification
REQ-029 SHALL test a nominal run: EX_time=10, Init pulse at edge 0 -> Expose high for 10 cycles, READOUT over edges 10-18, Done at edge 18.
REQ-030 SHALL test clamping: EX_time=0 -> 2-cycle exposure; EX_time=31 -> 30-cycle exposure.
REQ-031 SHALL test an EX_time change mid-run: EX_time=5, Init, then EX_time=20 at cycle 2 -> exposure stays 5 cycles; the next run uses 20.
REQ-032 SHALL test Init during Busy: Init pulses in EXPOSE and READOUT -> no effect on timing and a single Done.
REQ-033 SHALL test reset mid-readout: Reset at phase p1 -> NRE_1=1 and ADC=0 immediately, IDLE state, no Done; the next Init runs normally.
REQ-034 SHALL check the readout invariant on every cycle: NRE_1 and NRE_2 never both low, and ADC high only when exactly one NRE is low.

Source files
------------

// File: rtl/exposure_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exposure_pkg : shared states, timing constants and exposure clamp helper
// Rev 1.0
// ---------------------------------------------------------------------------
package exposure_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXPOSE  = 2'd1,
      READOUT = 2'd2
   } state_t;

   localparam logic [4:0] EXP_MIN     = 5'd2;
   localparam logic [4:0] EXP_MAX     = 5'd30;
   localparam int         READOUT_LEN = 8;
   localparam logic [2:0] PHASE_LAST  = 3'(READOUT_LEN - 1);

   function automatic logic [4:0] clamp_exp(input logic [4:0] v);
      if (v < EXP_MIN)
         return EXP_MIN;
      else if (v > EXP_MAX)
         return EXP_MAX;
      else
         return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/exposure_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exposure_counter : clamped 5-bit load, down-count, saturating terminal flag
// Rev 1.0
// ---------------------------------------------------------------------------
module exposure_counter
   import exposure_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [4:0] load_val,
   input  logic       dec,
   output logic       tc
);

   logic [4:0] r_count;

   // Terminal count is 1: the cycle holding 1 is the last exposure cycle.
   assign tc = (r_count <= 5'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (load)
         r_count <= clamp_exp(load_val);
      else if (dec && !tc)
         r_count <= r_count - 5'd1;
   end

endmodule
`default_nettype wire

// File: rtl/exposure_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exposure_seq : pixel exposure + two-row readout sequencer, registered outputs
// Rev 1.0
// ---------------------------------------------------------------------------
module exposure_seq
   import exposure_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Init,
   input  logic [4:0] EX_time,
   output logic       Erase,
   output logic       Expose,
   output logic       NRE_1,
   output logic       NRE_2,
   output logic       ADC,
   output logic       Busy,
   output logic       Done
);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_phase;
   logic [2:0] w_phase_nxt;
   logic       w_load;
   logic       w_dec;
   logic       w_tc;

   logic       w_erase;
   logic       w_expose;
   logic       w_nre_1;
   logic       w_nre_2;
   logic       w_adc;
   logic       w_busy;
   logic       w_done;

   exposure_counter u_exposure_counter (
      .clk      (Clk),
      .rst      (Reset),
      .load     (w_load),
      .load_val (EX_time),
      .dec      (w_dec),
      .tc       (w_tc)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
         r_phase <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
      end
   end

   // Outputs are decoded from the next state so they can be registered
   // and still line up with the state change on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      w_done      = 1'b0;

      case (r_state)
         IDLE: begin
            if (Init) begin
               w_state_nxt = EXPOSE;
               w_load      = 1'b1;
            end
         end
         EXPOSE: begin
            w_dec = 1'b1;
            if (w_tc) begin
               w_state_nxt = READOUT;
               w_phase_nxt = '0;
            end
         end
         READOUT: begin
            if (r_phase == PHASE_LAST) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end else begin
               w_phase_nxt = r_phase + 3'd1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      w_erase  = 1'b1;
      w_expose = 1'b0;
      w_nre_1  = 1'b1;
      w_nre_2  = 1'b1;
      w_adc    = 1'b0;
      w_busy   = (w_state_nxt != IDLE);

      case (w_state_nxt)
         EXPOSE: begin
            w_erase  = 1'b0;
            w_expose = 1'b1;
         end
         READOUT: begin
            w_erase = 1'b0;
            case (w_phase_nxt)
               3'd0: w_nre_1 = 1'b0;
               3'd1: begin w_nre_1 = 1'b0; w_adc = 1'b1; end
               3'd4: w_nre_2 = 1'b0;
               3'd5: begin w_nre_2 = 1'b0; w_adc = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Erase  <= 1'b1;
         Expose <= 1'b0;
         NRE_1  <= 1'b1;
         NRE_2  <= 1'b1;
         ADC    <= 1'b0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
      end else begin
         Erase  <= w_erase;
         Expose <= w_expose;
         NRE_1  <= w_nre_1;
         NRE_2  <= w_nre_2;
         ADC    <= w_adc;
         Busy   <= w_busy;
         Done   <= w_done;
      end
   end

endmodule
`default_nettype wire
